mem_arbiter: RTL and testbench

// - Shares one single-ported, variable-latency memory between the CPU instruction-fetch port and the data load/store port.
// - Sits between the cpu top level (pc/inst, address/load_data/store_data/mem_load/mem_store) and the memory.
// - Serialises accesses, returns read data and produces per-port stall signals for the hazard unit.
// - Runs a store as read-then-write so that su can merge sub-word stores into the loaded word.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_pkg: shared types and defaults for mem_arbiter       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRD    = 3'd2,
    ST_DWR    = 3'd3,
    ST_RESP_I = 3'd4,
    ST_RESP_D = 3'd5
  } arb_state_e;

  // Counter must be able to hold the value STARVE_LIMIT itself.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if: fetch port, data port and memory port bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_valid;
  logic            if_stall;

  logic            d_load;
  logic            d_store;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            d_stall;

  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_ack;
  logic [XLEN-1:0] m_rdata;

  // Arbiter view.
  modport master (
    input  if_req, if_addr, d_load, d_store, d_addr, d_wdata, m_ack, m_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata
  );

  // CPU + memory view.
  modport slave (
    output if_req, if_addr, d_load, d_store, d_addr, d_wdata, m_ack, m_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter: shares one memory between fetch and load/store port |
// | Option macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard)   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  arb_state_e      r_state;
  arb_state_e      w_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_d_rdata;
  logic            r_is_store;

  logic            w_d_pend;
  logic            w_idle;
  logic            w_fetch_first;
  logic            w_grant_d;
  logic            w_grant_i;
  logic            w_m_req;
  logic            w_m_we;
  logic [XLEN-1:0] w_m_wdata;
  logic            w_if_valid;
  logic            w_d_valid;

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  assign w_d_pend = bus.d_load | bus.d_store;
  assign w_idle   = (r_state == ST_IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
  logic [CNT_W-1:0] r_starve;

  assign w_fetch_first = bus.if_req & w_d_pend & (r_starve == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_grant_d && bus.if_req) begin
      r_starve <= r_starve + CNT_W'(1);
    end else if (w_grant_i) begin
      r_starve <= '0;
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  // Data is the older instruction in the pipeline, so it normally wins.
  assign w_grant_d = w_idle & w_d_pend & ~w_fetch_first;
  assign w_grant_i = w_idle & bus.if_req & ~w_grant_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      // Word-aligned address, held across both phases of a store.
      if (w_grant_d) begin
        r_addr     <= bus.d_addr & ~XLEN'(3);
        r_is_store <= bus.d_store;
      end else if (w_grant_i) begin
        r_addr     <= bus.if_addr & ~XLEN'(3);
      end
      if (r_state == ST_FETCH && bus.m_ack) r_if_rdata <= bus.m_rdata;
      if (r_state == ST_DRD && bus.m_ack)   r_d_rdata  <= bus.m_rdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_m_req    = 1'b0;
    w_m_we     = 1'b0;
    w_m_wdata  = '0;
    w_if_valid = 1'b0;
    w_d_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d)      w_next = ST_DRD;
        else if (w_grant_i) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_m_req = 1'b1;
        if (bus.m_ack) w_next = ST_RESP_I;
      end
      ST_DRD: begin
        w_m_req = 1'b1;
        if (bus.m_ack) w_next = r_is_store ? ST_DWR : ST_RESP_D;
      end
      ST_DWR: begin
        w_m_req   = 1'b1;
        w_m_we    = 1'b1;
        w_m_wdata = bus.d_wdata;
        if (bus.m_ack) w_next = ST_RESP_D;
      end
      ST_RESP_I: begin
        w_if_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      ST_RESP_D: begin
        w_d_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.m_req    = w_m_req;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.if_rdata = r_if_rdata;
  assign bus.if_valid = w_if_valid;
  assign bus.if_stall = bus.if_req & ~w_if_valid;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.d_valid  = w_d_valid;
  assign bus.d_stall  = w_d_pend & ~w_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter: directed and randomized checks of mem_arbiter    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: unwritten words read as a hash of their word index.
  function automatic logic [31:0] hash(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  logic [31:0] mem     [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] mem_rd(input int w);
    return mem.exists(w) ? mem[w] : hash(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : hash(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane, input logic [7:0] b);
    logic [31:0] m;
    m = 32'hFF << (8 * lane);
    return (w & ~m) | (32'(b) << (8 * lane));
  endfunction

  // Store unit: merges one byte into the pre-write word.
  logic [1:0] st_lane = 2'd0;
  logic [7:0] st_byte = 8'd0;
  assign bus.d_wdata = merge(bus.d_rdata, st_lane, st_byte);

  // Memory responder: ack after 'lat' wait cycles, log each completed access.
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  acc_t        acc_log[$];
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  int          waitc     = 0;
  int          lat       = 0;
  int          fix_lat   = 0;
  bit          spur_en   = 1'b0;
  assign bus.m_ack   = mem_ack;
  assign bus.m_rdata = mem_rdata;

  function automatic int pick_lat();
    return (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
  endfunction

  always @(negedge clock) begin
    if (mem_ack || !bus.m_req) begin
      waitc = 0;
      lat   = pick_lat();
    end
    mem_ack = 1'b0;
    if (bus.m_req) begin
      if (waitc >= lat) begin
        mem_ack = 1'b1;
        acc_log.push_back({bus.m_we, bus.m_addr, bus.m_wdata});
        if (bus.m_we) mem[int'(bus.m_addr >> 2)] = bus.m_wdata;
        else          mem_rdata = mem_rd(int'(bus.m_addr >> 2));
      end else begin
        waitc++;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end
  end

  // Observation of directed scenarios.
  int          cyc, n_iv, n_dv, iv_at, dv_at, we_seen, req_cycles, addr_unstable, stall_bad;
  logic [31:0] grants[$];
  logic        prev_req;
  logic [31:0] prev_addr;

  task automatic clear_obs();
    cyc = 0; n_iv = 0; n_dv = 0; iv_at = -1; dv_at = -1;
    we_seen = 0; req_cycles = 0; addr_unstable = 0; stall_bad = 0;
    grants.delete();
    prev_req  = bus.m_req;
    prev_addr = bus.m_addr;
  endtask

  task automatic observe(input int n, input bit auto_drop);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (bus.if_stall !== (bus.if_req & ~bus.if_valid)) stall_bad++;
      if (bus.d_stall !== ((bus.d_load | bus.d_store) & ~bus.d_valid)) stall_bad++;
      if (bus.m_we)  we_seen++;
      if (bus.m_req) req_cycles++;
      if (bus.m_req && !prev_req) grants.push_back(bus.m_addr);
      if (bus.m_req && prev_req && bus.m_addr !== prev_addr) addr_unstable++;
      prev_req  = bus.m_req;
      prev_addr = bus.m_addr;
      if (bus.if_valid) begin
        n_iv++;
        if (iv_at < 0) iv_at = cyc;
        if (auto_drop) bus.if_req = 1'b0;
      end
      if (bus.d_valid) begin
        n_dv++;
        if (dv_at < 0) dv_at = cyc;
        if (auto_drop) begin bus.d_load = 1'b0; bus.d_store = 1'b0; end
      end
    end
  endtask

  initial begin
    int          i_age, d_age, w, n_fetch4, kind, w_off;
    bit          d_is_store, drain;
    logic [31:0] exp;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_load = 1'b0; bus.d_store = 1'b0; bus.d_addr = '0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_m_req",    bus.m_req,    0);
    check("rst_m_we",     bus.m_we,     0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_d_valid",  bus.d_valid,  0);
    check("rst_m_addr",   bus.m_addr,   0);
    check("rst_m_wdata",  bus.m_wdata,  0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata,  0);
    reset = 1'b0;
    observe(2, 1'b0);

    // Fetch only, ack one cycle after m_req rises
    fix_lat = 1;
    mem[int'(32'h100 >> 2)] = 32'h0000_0013;
    clear_obs();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    observe(6, 1'b1);
    check("fetch_valid_cycle", iv_at, 3);
    check("fetch_pulses",      n_iv, 1);
    check("fetch_rdata",       bus.if_rdata, 32'h13);
    check("fetch_no_we",       we_seen, 0);
    check("fetch_addr",        grants[0], 32'h100);

    // Simultaneous fetch and load: data first
    fix_lat = 0;
    mem[int'(32'h104 >> 2)]  = 32'h00A0_0093;
    mem[int'(32'h2000 >> 2)] = 32'hCAFE_0001;
    clear_obs();
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_load = 1'b1; bus.d_addr  = 32'h2000;
    observe(8, 1'b1);
    check("prio_grants",   grants.size(), 2);
    check("prio_first",    grants[0], 32'h2000);
    check("prio_second",   grants[1], 32'h104);
    check("prio_d_cycle",  dv_at, 2);
    check("prio_i_cycle",  iv_at, 5);
    check("prio_stall",    stall_bad, 0);
    check("prio_d_rdata",  bus.d_rdata, 32'hCAFE_0001);
    check("prio_if_rdata", bus.if_rdata, 32'h00A0_0093);

    // Sub-word store: read-then-write at the aligned address
    mem[int'(32'h2000 >> 2)] = 32'hAABB_CCDD;
    acc_log.delete();
    clear_obs();
    st_lane = 2'd2; st_byte = 8'h11;
    bus.d_store = 1'b1; bus.d_addr = 32'h2002;
    observe(6, 1'b1);
    check("st_accesses",  acc_log.size(), 2);
    check("st_rd_phase",  {acc_log[0].we, acc_log[0].addr}, {1'b0, 32'h2000});
    check("st_wr_phase",  {acc_log[1].we, acc_log[1].addr}, {1'b1, 32'h2000});
    check("st_wdata",     acc_log[1].wdata, 32'hAA11_CCDD);
    check("st_pulses",    n_dv, 1);
    check("st_cycle",     dv_at, 3);
    check("st_old_word",  bus.d_rdata, 32'hAABB_CCDD);

    // Slow memory: ack held low five cycles
    fix_lat = 5;
    mem[int'(32'h2010 >> 2)] = 32'h0BAD_F00D;
    clear_obs();
    bus.d_load = 1'b1; bus.d_addr = 32'h2010;
    observe(10, 1'b1);
    check("slow_cycle",    dv_at, 7);
    check("slow_req_len",  req_cycles, 6);
    check("slow_addr",     addr_unstable, 0);
    check("slow_grant",    grants[0], 32'h2010);
    check("slow_stall",    stall_bad, 0);
    check("slow_rdata",    bus.d_rdata, 32'h0BAD_F00D);

    // Request dropped mid-transaction still completes
    fix_lat = 2;
    mem[int'(32'h2018 >> 2)] = 32'h600D_CAFE;
    clear_obs();
    bus.d_load = 1'b1; bus.d_addr = 32'h2018;
    observe(1, 1'b1);
    bus.d_load = 1'b0;
    observe(6, 1'b1);
    check("drop_cycle",  dv_at, 4);
    check("drop_pulses", n_dv, 1);
    check("drop_rdata",  bus.d_rdata, 32'h600D_CAFE);

    // Reset during the read phase abandons the access
    fix_lat = 10;
    mem[int'(32'h2020 >> 2)] = 32'h1234_5678;
    clear_obs();
    bus.d_load = 1'b1; bus.d_addr = 32'h2020;
    observe(1, 1'b0);
    check("mid_rst_req_before", bus.m_req, 1);
    reset = 1'b1; bus.d_load = 1'b0;
    observe(1, 1'b0);
    check("mid_rst_req_after", bus.m_req, 0);
    check("mid_rst_rdata",     bus.d_rdata, 0);
    reset = 1'b0;
    observe(5, 1'b0);
    check("mid_rst_no_valid", n_dv, 0);
    fix_lat = 0;
    clear_obs();
    bus.d_load = 1'b1; bus.d_addr = 32'h2020;
    observe(4, 1'b1);
    check("mid_rst_retry_cycle", dv_at, 2);
    check("mid_rst_retry_rdata", bus.d_rdata, 32'h1234_5678);

    // Continuous data traffic with a waiting fetch
    clear_obs();
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    bus.d_load = 1'b1; bus.d_addr  = 32'h2030;
    observe(20, 1'b0);
    n_fetch4 = 0;
    for (int g = 0; g < 4; g++) if (grants[g] == 32'h108) n_fetch4++;
    check("starve_first4", n_fetch4, 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_5th", grants[4], 32'h108);
`else
    check("starve_5th", grants[4], 32'h2030);
`endif
    bus.if_req = 1'b0; bus.d_load = 1'b0;
    observe(4, 1'b0);

    // Randomized traffic against a word-level memory model
    mem.delete(); ref_mem.delete();
    fix_lat = -1; spur_en = 1'b1;
    i_age = 0; d_age = 0; d_is_store = 1'b0; drain = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clock);
      #1;
      drain = (c >= 600);
      if (bus.if_req) begin
        if (bus.if_valid) begin
          check("rnd_fetch", bus.if_rdata, hash(int'(bus.if_addr >> 2)));
          bus.if_req = 1'b0; i_age = 0;
        end else if (++i_age > 50) begin
          check("rnd_fetch_timeout", i_age, 0);
          bus.if_req = 1'b0; i_age = 0;
        end
      end else if (!drain && $urandom_range(0, 3) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (bus.d_load || bus.d_store) begin
        if (bus.d_valid) begin
          w   = int'(bus.d_addr >> 2);
          exp = ref_rd(w);
          if (d_is_store) begin
            check("rnd_store_old", bus.d_rdata, exp);
            ref_mem[w] = merge(exp, st_lane, st_byte);
          end else begin
            check("rnd_load", bus.d_rdata, exp);
          end
          bus.d_load = 1'b0; bus.d_store = 1'b0; d_age = 0;
        end else if (++d_age > 50) begin
          check("rnd_data_timeout", d_age, 0);
          bus.d_load = 1'b0; bus.d_store = 1'b0; d_age = 0;
        end
      end else if (!drain && $urandom_range(0, 2) == 0) begin
        kind        = int'($urandom_range(0, 2));
        w_off       = int'($urandom_range(0, 15));
        st_lane     = 2'($urandom_range(0, 3));
        st_byte     = 8'($urandom);
        d_is_store  = (kind != 0);
        bus.d_load  = (kind != 1);
        bus.d_store = (kind != 0);
        bus.d_addr  = 32'h2000 + (32'(w_off) << 2) + (d_is_store ? 32'(st_lane) : 32'd0);
      end
    end
    check("rnd_drained", {bus.if_req, bus.d_load | bus.d_store}, 0);
    for (int k = 0; k < 16; k++) begin
      check("rnd_mem_word", mem_rd(int'(32'h2000 >> 2) + k), ref_rd(int'(32'h2000 >> 2) + k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
